vedm_telemetry_tx: RTL
======================

// Module: vedm_telemetry_tx
// PURPOSE
// - Transmit end of the voltage-sample datapath. Accepts 8-bit converted-voltage samples
//   over a valid/ready handshake and buffers them in a small FIFO.
// - Serialises each sample onto a single UART-style line as a 3-byte frame: SYNC, SAMPLE, CHECKSUM.
// - Sits between the sampling register and an output pin, giving the off-chip data logger a telemetry stream.
// PARAMETERS
// - CLKS_PER_BIT  16     clk cycles each serial bit is held; legal range >= 2
// - FIFO_DEPTH    4      sample FIFO entries; must be a power of 2, >= 2
// - SYNC_BYTE     8'hA5  first byte of every frame
// PORTS
// - clk          in   1  clock
// - rst_n        in   1  reset, asynchronous, active-low
// - ena          in   1  enable; gates acceptance and new-frame start
// - in_data      in   8  voltage sample
// - in_valid     in   1  in_data valid
// - in_ready     out  1  FIFO can accept; combinational = ena & !fifo_full
// - tx           out  1  serial line, idle high, registered
// - busy         out  1  high while a frame is being shifted (any state except IDLE), registered
// - frame_count  out  8  completed frames, wraps 255->0
// BEHAVIOUR
// - Reset values: tx=1, busy=0, frame_count=0, FIFO empty, FSM=IDLE.
//   in_ready follows ena once reset is released.
// - Reset asserted mid-frame: tx returns to 1 immediately (asynchronous), FIFO contents are discarded,
//   and no partial frame resumes after release.
// - Push: a sample is written on any edge where in_valid & in_ready.
//   - When full, in_ready=0 and no sample is accepted, even if a pop occurs on the same edge.
//   - Push and pop on the same edge when not full: both take effect; the count is unchanged.
// - FSM states: IDLE -> START -> DATA -> STOP -> (START of next byte | IDLE).
//   - IDLE: if ena & FIFO non-empty, pop one sample, latch it, set byte_idx=0, go to START.
//   - START: tx=0 for CLKS_PER_BIT cycles.
//   - DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles.
//   - STOP: tx=1 for CLKS_PER_BIT cycles.
//     - If byte_idx<2: increment byte_idx, go to START with no gap.
//     - Else: frame_count++, go to IDLE.
// - Byte order: byte_idx 0 = SYNC_BYTE, 1 = sample, 2 = SYNC_BYTE ^ sample.
// - Latency: a sample accepted on edge E into an empty FIFO, while IDLE and ena=1, drives tx=0 from edge E+1.
// - Frame length is 3*10*CLKS_PER_BIT cycles, or 3*11*CLKS_PER_BIT with the parity option.
//   IDLE lasts at least 1 cycle between frames, so back-to-back frames have exactly one cycle of tx=1 between them.
// - ena low:
//   - in_ready=0.
//   - A frame in progress completes in full.
//   - IDLE does not pop; buffered samples are retained until ena returns.
// - busy is 0 only in IDLE. The bit counter and cycle counter are sized from the parameters.
// CONFIGURATION
// - Macro TELEM_TX_PARITY_EN.
//   - Defined: a PARITY state is inserted between DATA and STOP. It drives the even-parity bit
//     (XOR of the 8 data bits) for CLKS_PER_BIT cycles, making each character 11 bits.
//   - Undefined: no PARITY state, 10-bit characters, and no parity logic is synthesised.
// TESTING (CLKS_PER_BIT=4, FIFO_DEPTH=4 unless noted)
// - Reset: rst_n=0 -> tx=1, busy=0, frame_count=0.
//   Release with ena=1 -> in_ready=1.
// - Single sample: in_data=8'h3C for one handshake.
//   - Line carries 8'hA5, 8'h3C, 8'h99, each LSB first with start and stop bits.
//   - Frame lasts 120 cycles, busy is high throughout, then frame_count=1.
// - Backpressure: 6 consecutive valid cycles with data 1..6.
//   - Samples 1..5 are accepted: 1 in flight, 4 buffered.
//   - in_ready=0 on the 6th until sample 2 is popped.
//   - Frames for 1..5 are sent in order, with 1-cycle idle gaps.
// - Enable gating: ena=0 asserted mid-frame with 2 samples buffered.
//   - The current frame completes.
//   - tx stays 1 and busy=0 indefinitely.
//   - ena=1 -> the next frame starts on the following edge.
// - Reset mid-DATA: pulse rst_n low during byte 1.
//   - tx=1 immediately, frame_count=0.
//   - FIFO is empty after release; no frame starts without a new push.
// - Parity build (TELEM_TX_PARITY_EN): sample 8'h01.
//   - Bytes are A5/01/A4 with parity bits 0/1/1.
//   - Frame lasts 132 cycles.

Source files
------------

// File: rtl/vedm_telemetry_tx.sv
// Telemetry transmitter: buffers 8-bit voltage samples in a FIFO and sends each as a
// SYNC/SAMPLE/CHECKSUM UART frame. Define TELEM_TX_PARITY_EN to add an even-parity bit per character.
module vedm_telemetry_tx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       tx,
  output logic       busy,
  output logic [7:0] frame_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_TOP = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef TELEM_TX_PARITY_EN
    PARITY = 3'd4,
`endif
    STOP   = 3'd3
  } state_t;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          full, empty, push, pop;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    bit_idx, bit_n;
  logic [1:0]    byte_idx, byte_n;
  logic [7:0]    sample, sample_n;
  logic [7:0]    cur;
  logic          tx_n, frame_done;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign in_ready = ena & ~full;
  assign push     = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  function automatic logic [7:0] frame_byte(input logic [1:0] idx, input logic [7:0] s);
    case (idx)
      2'd0:    frame_byte = SYNC_BYTE;
      2'd1:    frame_byte = s;
      default: frame_byte = SYNC_BYTE ^ s;
    endcase
  endfunction

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    bit_n      = bit_idx;
    byte_n     = byte_idx;
    sample_n   = sample;
    pop        = 1'b0;
    frame_done = 1'b0;
    case (state)
      IDLE: if (ena && !empty) begin
        pop      = 1'b1;
        sample_n = mem[rd_ptr[AW-1:0]];
        byte_n   = 2'd0;
        cnt_n    = CNT_TOP;
        state_n  = START;
      end
      START: if (cnt == '0) begin
        cnt_n   = CNT_TOP;
        bit_n   = 3'd0;
        state_n = DATA;
      end else cnt_n = cnt - CW'(1);
      DATA: if (cnt == '0) begin
        cnt_n = CNT_TOP;
        if (bit_idx == 3'd7) begin
`ifdef TELEM_TX_PARITY_EN
          state_n = PARITY;
`else
          state_n = STOP;
`endif
        end else bit_n = bit_idx + 3'd1;
      end else cnt_n = cnt - CW'(1);
`ifdef TELEM_TX_PARITY_EN
      PARITY: if (cnt == '0) begin
        cnt_n   = CNT_TOP;
        state_n = STOP;
      end else cnt_n = cnt - CW'(1);
`endif
      STOP: if (cnt == '0) begin
        if (byte_idx != 2'd2) begin
          byte_n  = byte_idx + 2'd1;
          cnt_n   = CNT_TOP;
          state_n = START;
        end else begin
          frame_done = 1'b1;
          state_n    = IDLE;
        end
      end else cnt_n = cnt - CW'(1);
      default: state_n = IDLE;
    endcase

    // tx is registered, so it is derived from where the FSM lands on this edge.
    cur  = frame_byte(byte_n, sample_n);
    tx_n = 1'b1;
    case (state_n)
      START:  tx_n = 1'b0;
      DATA:   tx_n = cur[bit_n];
`ifdef TELEM_TX_PARITY_EN
      PARITY: tx_n = ^cur;
`endif
      default: tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_idx     <= 3'd0;
      byte_idx    <= 2'd0;
      sample      <= 8'd0;
      tx          <= 1'b1;
      busy        <= 1'b0;
      frame_count <= 8'd0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      bit_idx  <= bit_n;
      byte_idx <= byte_n;
      sample   <= sample_n;
      tx       <= tx_n;
      busy     <= (state_n != IDLE);
      if (frame_done) frame_count <= frame_count + 8'd1;
    end
  end
endmodule
